store_buffer: RTL and testbench

//  Posted-write buffer between the MIPS core memory-stage port and data memory.

---
 rtl/mips_pkg.sv | 13 +
 rtl/sb_fwd_match.sv | 34 +++
 rtl/store_buffer.sv | 88 ++++++++
 tb/tb_store_buffer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS memory-stage types: address/data widths and the store buffer entry layout.
package mips_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Word address only; byte offset bits are never stored.
    typedef struct packed {
        logic [ADDR_W-3:0] waddr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Age-ordered store-to-load forwarding match: walks queued entries oldest to youngest
// so the youngest matching entry wins.
module sb_fwd_match
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  sb_entry_t [DEPTH-1:0] i_entries,
    input  logic [PW-1:0]         i_head,
    input  logic [CW-1:0]         i_count,
    input  logic [ADDR_W-3:0]     i_key,
    output logic                  o_hit,
    output logic [DATA_W-1:0]     o_data
);

    logic [PW-1:0] w_idx;

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = i_head;
        for (int k = 0; k < DEPTH; k++) begin
            // Offset k from head is age order; pointer wrap is free since DEPTH is a power of two.
            w_idx = i_head + PW'(k);
            if ((CW'(k) < i_count) && (i_entries[w_idx].waddr == i_key)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the memory stage and data memory: single-cycle store
// accept, in-order drain over valid/ready, youngest-match forwarding for loads.
module store_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int DATA_W = mips_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemWriteM,
    input  logic              MemReadM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wvalid,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wready,
    output logic              sb_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    sb_entry_t [DEPTH-1:0] r_entries;
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_hit;
    logic [DATA_W-1:0] w_fwd_data;
    logic              w_unused;

    // MemReadM is not needed: ReadDataM is driven by the load rule every cycle.
    assign w_unused = ^{MemReadM, ALUResultM[1:0]};

    assign w_full     = (r_count == CW'(DEPTH));
    // A full queue refuses the store even if the head pops this cycle.
    assign w_push     = MemWriteM & ~w_full;
    assign w_pop      = mem_wvalid & mem_wready;
    assign StallM     = MemWriteM & w_full;
    assign sb_empty   = (r_count == '0);

    assign mem_wvalid = ~sb_empty;
    assign mem_waddr  = {r_entries[r_head].waddr, 2'b00};
    assign mem_wdata  = r_entries[r_head].data;
    assign mem_raddr  = {ALUResultM[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Entry storage needs no reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entries[r_tail].waddr <= ALUResultM[ADDR_W-1:2];
            r_entries[r_tail].data  <= WriteDataM;
        end
    end

    sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
        .i_entries (r_entries),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_key     (ALUResultM[ADDR_W-1:2]),
        .o_hit     (w_hit),
        .o_data    (w_fwd_data)
    );

    assign ReadDataM = w_hit ? w_fwd_data : mem_rdata;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected drain writes are queued as stores are driven
// and checked in order by a negedge monitor; forwarding/stall checks are inline per task.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemWriteM = 1'b0;
    logic        MemReadM = 1'b0;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata = '0;
    logic        mem_wvalid;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wready = 1'b0;
    logic        sb_empty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_wvalid (mem_wvalid),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready),
        .sb_empty   (sb_empty)
    );

    // Drain monitor: every handshake must match the oldest expected store.
    always @(negedge clk) begin
        if (!rst && mem_wvalid && mem_wready) begin
            logic [63:0] exp_w;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL drain_unexpected: write addr=%h data=%h, required no write", mem_waddr, mem_wdata);
            end else begin
                exp_w = sb_q.pop_front();
                if ({mem_waddr, mem_wdata} !== exp_w) begin
                    n_fail++;
                    $display("FAIL drain_order: got %h/%h, required %h/%h",
                             mem_waddr, mem_wdata, exp_w[63:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input bit exp_push);
        MemWriteM  = 1'b1;
        MemReadM   = 1'b0;
        ALUResultM = a;
        WriteDataM = d;
        if (exp_push) sb_q.push_back({a & 32'hFFFF_FFFC, d});
    endtask

    task automatic wait_empty(input int max_cycles);
        int k;
        for (k = 0; k < max_cycles; k++) begin
            if (sb_empty === 1'b1 && sb_q.size() == 0) break;
            step();
        end
        n_checks++;
        if (k == max_cycles) begin
            n_fail++;
            $display("FAIL drain_timeout: sb_empty=%b pending=%0d after %0d cycles, required empty", sb_empty, sb_q.size(), max_cycles);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ALUResultM = 32'h0000_0103;
        mem_rdata  = 32'h1234_5678;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_wvalid !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid: got %b, required 0", mem_wvalid); end
        n_checks++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, required 0", StallM); end
        n_checks++; if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b, required 1", sb_empty); end
        n_checks++; if (ReadDataM !== 32'h1234_5678) begin n_fail++; $display("FAIL reset_rdata: got %h, required 12345678", ReadDataM); end
        n_checks++; if (mem_raddr !== 32'h0000_0100) begin n_fail++; $display("FAIL reset_raddr: got %h, required 00000100", mem_raddr); end
    endtask

    task automatic test_single_store();
        step();
        mem_wready = 1'b1;
        drive_store(32'h100, 32'h11, 1'b1);
        @(negedge clk);
        n_checks++; if (mem_wvalid !== 1'b0) begin n_fail++; $display("FAIL no_bypass: wvalid got %b, required 0", mem_wvalid); end
        step();
        MemWriteM = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_wvalid !== 1'b1) begin n_fail++; $display("FAIL single_wvalid: got %b, required 1", mem_wvalid); end
        n_checks++; if (mem_waddr !== 32'h100) begin n_fail++; $display("FAIL single_waddr: got %h, required 00000100", mem_waddr); end
        step();
        @(negedge clk);
        n_checks++; if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_after: got %b, required 1", sb_empty); end
    endtask

    task automatic test_forward_youngest();
        step();
        mem_wready = 1'b0;
        drive_store(32'h100, 32'hAA, 1'b1);
        step();
        drive_store(32'h100, 32'hBB, 1'b1);
        step();
        MemWriteM  = 1'b0;
        MemReadM   = 1'b1;
        ALUResultM = 32'h102;
        mem_rdata  = 32'hDEAD;
        @(negedge clk);
        n_checks++; if (ReadDataM !== 32'hBB) begin n_fail++; $display("FAIL fwd_youngest: got %h, required 000000bb", ReadDataM); end
        n_checks++; if (mem_wdata !== 32'hAA) begin n_fail++; $display("FAIL head_hold: got %h, required 000000aa", mem_wdata); end
        step();
        MemReadM   = 1'b0;
        mem_wready = 1'b1;
        wait_empty(20);
    endtask

    task automatic test_full_stall();
        step();
        mem_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_store(32'h300 + 32'(4 * i), 32'(i + 1), 1'b1);
            step();
        end
        drive_store(32'h310, 32'h5, 1'b0);
        @(negedge clk);
        n_checks++; if (StallM !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b, required 1", StallM); end
        step();
        @(negedge clk);
        n_checks++; if (StallM !== 1'b1) begin n_fail++; $display("FAIL full_hold: got %b, required 1", StallM); end
        step();
        mem_wready = 1'b1;
        sb_q.push_back({32'h310, 32'h5});
        @(negedge clk);
        n_checks++; if (StallM !== 1'b1) begin n_fail++; $display("FAIL full_pop_no_enq: got %b, required 1", StallM); end
        step();
        @(negedge clk);
        n_checks++; if (StallM !== 1'b0) begin n_fail++; $display("FAIL full_accept: got %b, required 0", StallM); end
        step();
        MemWriteM = 1'b0;
        wait_empty(20);
    endtask

    task automatic test_miss_and_pop_forward();
        step();
        mem_wready = 1'b0;
        mem_rdata  = 32'hDEAD;
        drive_store(32'h100, 32'h55, 1'b1);
        @(negedge clk);
        n_checks++; if (ReadDataM !== 32'hDEAD) begin n_fail++; $display("FAIL no_same_cycle_fwd: got %h, required 0000dead", ReadDataM); end
        step();
        MemWriteM  = 1'b0;
        MemReadM   = 1'b1;
        ALUResultM = 32'h200;
        @(negedge clk);
        n_checks++; if (ReadDataM !== 32'hDEAD) begin n_fail++; $display("FAIL load_miss: got %h, required 0000dead", ReadDataM); end
        step();
        ALUResultM = 32'h100;
        mem_wready = 1'b1;
        @(negedge clk);
        n_checks++; if (ReadDataM !== 32'h55) begin n_fail++; $display("FAIL fwd_pop_cycle: got %h, required 00000055", ReadDataM); end
        step();
        @(negedge clk);
        n_checks++; if (ReadDataM !== 32'hDEAD) begin n_fail++; $display("FAIL after_pop_miss: got %h, required 0000dead", ReadDataM); end
        MemReadM = 1'b0;
        wait_empty(5);
    endtask

    task automatic test_reset_mid_drain();
        step();
        mem_wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h500 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0);
            step();
        end
        MemWriteM = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_wvalid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_wvalid: got %b, required 1", mem_wvalid); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_wready = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_wvalid !== 1'b0) begin n_fail++; $display("FAIL post_reset_wvalid: got %b, required 0", mem_wvalid); end
        n_checks++; if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL post_reset_empty: got %b, required 1", sb_empty); end
        repeat (4) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_store();
        test_forward_youngest();
        test_full_stall();
        test_miss_and_pop_forward();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
